// File: rtl/mlp_seq_pkg.sv
// Shared types and defaults for the MLP feature sequencer: FSM state encoding,
// default feature/class widths and the feat_vec slice addressing helper.
package mlp_seq_pkg;

   localparam int unsigned DEF_N_FEAT = 6;
   localparam int unsigned DEF_FEAT_W = 4;
   localparam int unsigned DEF_CLS_W  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CONV,
      S_WAIT,
      S_EVAL
   } seq_state_t;

   // Bit offset of channel ch inside the packed feature vector (channel 0 in the LSBs).
   function automatic int unsigned slice_base(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/mlp_seq_cnt.sv
// Loadable down-counter with a zero flag; stops at zero. Load wins over count.
module mlp_seq_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mlp_feature_sequencer.sv
// Steps a shared SAR ADC across N_FEAT channels, packs results into feat_vec and latches the classifier output.
// Define MLP_SEQ_TIMEOUT_EN to add the ADC watchdog and the sticky adc_err output.
module mlp_feature_sequencer
   import mlp_seq_pkg::*;
#(
   parameter int unsigned N_FEAT      = DEF_N_FEAT,
   parameter int unsigned FEAT_W      = DEF_FEAT_W,
   parameter int unsigned CLS_W       = DEF_CLS_W,
   parameter int unsigned SETTLE_CYC  = 2,
   parameter int unsigned EVAL_CYC    = 3,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic [$clog2(N_FEAT)-1:0]  adc_ch_sel,
   output logic                       adc_conv,
   input  logic                       adc_done,
   input  logic [FEAT_W-1:0]          adc_data,
   output logic [N_FEAT*FEAT_W-1:0]   feat_vec,
   input  logic [CLS_W-1:0]           cls_in,
   output logic [CLS_W-1:0]           cls_out,
   output logic                       cls_valid,
   output logic                       busy
`ifdef MLP_SEQ_TIMEOUT_EN
   ,
   output logic                       adc_err
`endif
);

   localparam int unsigned CH_W    = $clog2(N_FEAT);
   // One counter width covers settle, eval and watchdog loads so both instances match.
   localparam int unsigned MAX_SE  = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
   localparam int unsigned CNT_MAX = (MAX_SE > TIMEOUT_CYC) ? MAX_SE : TIMEOUT_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] EVAL_LD   = CNT_W'(EVAL_CYC - 1);
   localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_FEAT - 1);

   seq_state_t                r_state;
   seq_state_t                w_state_nxt;
   logic [CH_W-1:0]           r_ch;
   logic [N_FEAT*FEAT_W-1:0]  r_feat;
   logic [CLS_W-1:0]          r_cls;
   logic                      r_cls_valid;

   logic                      w_cnt_load;
   logic [CNT_W-1:0]          w_cnt_val;
   logic                      w_cnt_en;
   logic                      w_cnt_zero;
   logic                      w_wr;
   logic [FEAT_W-1:0]         w_wr_data;
   logic                      w_ch_clr;
   logic                      w_ch_inc;
   logic                      w_cls_latch;
   logic                      w_to_fire;

   assign w_cnt_en = (r_state == S_SETTLE) || (r_state == S_EVAL);

   mlp_seq_cnt #(.W(CNT_W)) u_phase_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_en       (w_cnt_en),
      .o_zero     (w_cnt_zero)
   );

`ifdef MLP_SEQ_TIMEOUT_EN
   logic w_to_load;
   logic w_to_en;
   logic w_to_zero;
   logic r_err;

   // Armed while in CONV so the first WAIT cycle already sees TIMEOUT_CYC-1.
   assign w_to_load = (r_state == S_CONV);
   assign w_to_en   = (r_state == S_WAIT);

   mlp_seq_cnt #(.W(CNT_W)) u_wait_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_to_load),
      .i_load_val (CNT_W'(TIMEOUT_CYC - 1)),
      .i_en       (w_to_en),
      .o_zero     (w_to_zero)
   );

   assign w_to_fire = (r_state == S_WAIT) && !adc_done && w_to_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_to_fire) begin
         r_err <= 1'b1;
      end
   end

   assign adc_err = r_err;
`else
   assign w_to_fire = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_load  = 1'b0;
      w_cnt_val   = SETTLE_LD;
      w_wr        = 1'b0;
      w_wr_data   = adc_data;
      w_ch_clr    = 1'b0;
      w_ch_inc    = 1'b0;
      w_cls_latch = 1'b0;
      adc_conv    = 1'b0;
      busy        = (r_state != S_IDLE);
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_SETTLE;
               w_ch_clr    = 1'b1;
               w_cnt_load  = 1'b1;
            end
         end
         S_SETTLE: begin
            if (w_cnt_zero) w_state_nxt = S_CONV;
         end
         S_CONV: begin
            adc_conv    = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A watchdog abort stores zero and then advances exactly like a real done.
            if (adc_done || w_to_fire) begin
               w_wr       = 1'b1;
               w_wr_data  = adc_done ? adc_data : '0;
               w_cnt_load = 1'b1;
               if (r_ch == LAST_CH) begin
                  w_state_nxt = S_EVAL;
                  w_cnt_val   = EVAL_LD;
               end else begin
                  w_state_nxt = S_SETTLE;
                  w_ch_inc    = 1'b1;
               end
            end
         end
         S_EVAL: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_IDLE;
               w_cls_latch = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ch        <= '0;
         r_feat      <= '0;
         r_cls       <= '0;
         r_cls_valid <= 1'b0;
      end else begin
         r_cls_valid <= w_cls_latch;
         if (w_ch_clr) begin
            r_ch <= '0;
         end else if (w_ch_inc) begin
            r_ch <= r_ch + 1'b1;
         end
         if (w_cls_latch) r_cls <= cls_in;
         for (int unsigned k = 0; k < N_FEAT; k++) begin
            if (w_wr && (r_ch == CH_W'(k))) begin
               r_feat[slice_base(k, FEAT_W) +: FEAT_W] <= w_wr_data;
            end
         end
      end
   end

   assign adc_ch_sel = r_ch;
   assign feat_vec   = r_feat;
   assign cls_out    = r_cls;
   assign cls_valid  = r_cls_valid;

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// Randomized bench for mlp_feature_sequencer with a reactive ADC model and a transaction-level reference.
// Define MLP_SEQ_TIMEOUT_EN to also exercise the ADC watchdog.
module tb_mlp_feature_sequencer;

   localparam int unsigned NF   = 6;
   localparam int unsigned FW   = 4;
   localparam int unsigned CW   = 2;
   localparam int unsigned SC   = 2;
   localparam int unsigned EC   = 3;
   localparam int unsigned TO   = 15;
   localparam int unsigned SELW = $clog2(NF);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              adc_done = 1'b0;
   logic [FW-1:0]     adc_data = '0;
   logic [CW-1:0]     cls_in = '0;
   logic [SELW-1:0]   adc_ch_sel;
   logic              adc_conv;
   logic [NF*FW-1:0]  feat_vec;
   logic [CW-1:0]     cls_out;
   logic              cls_valid;
   logic              busy;
`ifdef MLP_SEQ_TIMEOUT_EN
   logic              adc_err;
`endif

   mlp_feature_sequencer #(
      .N_FEAT      (NF),
      .FEAT_W      (FW),
      .CLS_W       (CW),
      .SETTLE_CYC  (SC),
      .EVAL_CYC    (EC),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .adc_ch_sel (adc_ch_sel),
      .adc_conv   (adc_conv),
      .adc_done   (adc_done),
      .adc_data   (adc_data),
      .feat_vec   (feat_vec),
      .cls_in     (cls_in),
      .cls_out    (cls_out),
      .cls_valid  (cls_valid),
      .busy       (busy)
`ifdef MLP_SEQ_TIMEOUT_EN
      ,
      .adc_err    (adc_err)
`endif
   );

   always #5 clk = ~clk;

   int unsigned   n_chk = 0;
   int unsigned   n_pass = 0;
   int unsigned   lat [NF];
   logic [FW-1:0] dat [NF];
   bit            silent [NF];
   int unsigned   conv_q [$];
   int unsigned   pend_cnt = 0;
   logic [FW-1:0] pend_dat = '0;
   bit            spur_arm = 1'b0;
   int unsigned   spur_ch = 2;
   logic [NF*FW-1:0] exp_feat = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // ADC model: done arrives lat[ch] cycles after the conversion pulse, with dat[ch].
   always @(negedge clk) begin
      adc_done = 1'b0;
      if (pend_cnt != 0) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            adc_done = 1'b1;
            adc_data = pend_dat;
         end
      end else if (spur_arm && busy && !adc_conv && (adc_ch_sel == SELW'(spur_ch))) begin
         adc_done = 1'b1;
         adc_data = '1;
         spur_arm = 1'b0;
      end
      if (adc_conv) begin
         conv_q.push_back(int'(adc_ch_sel));
         if (!silent[adc_ch_sel]) begin
            pend_cnt = lat[adc_ch_sel];
            pend_dat = dat[adc_ch_sel];
         end
      end
   end

   function automatic void randomize_adc();
      for (int k = 0; k < NF; k++) begin
         dat[k]    = FW'($urandom);
         lat[k]    = $urandom_range(1, 6);
         silent[k] = 1'b0;
      end
   endfunction

   function automatic int unsigned exp_lat();
      int unsigned s = 1 + EC;
      for (int k = 0; k < NF; k++) s += SC + 1 + (silent[k] ? TO : lat[k]);
      return s;
   endfunction

   function automatic void model_feat();
      for (int k = 0; k < NF; k++) exp_feat[k*FW +: FW] = silent[k] ? '0 : dat[k];
   endfunction

   // Called right after a negedge; hold keeps start high through the run.
   task automatic run(input string tag, input bit hold, input int unsigned mid, input logic [CW-1:0] cls);
      int unsigned n = 0;
      bit ok = 1'b0;
      conv_q.delete();
      cls_in = cls;
      model_feat();
      start = 1'b1;
      while (n < 2000 && !ok) begin
         @(negedge clk);
         n++;
         if (!hold) start = (mid != 0) && (n == mid);
         ok = cls_valid;
      end
      chk({tag, "_done"}, 64'(ok), 64'(1));
      chk({tag, "_lat"}, 64'(n), 64'(exp_lat()));
      chk({tag, "_feat"}, 64'(feat_vec), 64'(exp_feat));
      chk({tag, "_cls"}, 64'(cls_out), 64'(cls));
      chk({tag, "_nconv"}, 64'(conv_q.size()), 64'(NF));
      for (int k = 0; k < conv_q.size() && k < NF; k++) chk({tag, "_order"}, 64'(conv_q[k]), 64'(k));
      if (!hold) begin
         @(negedge clk);
         chk({tag, "_vpulse"}, 64'(cls_valid), 64'(0));
         chk({tag, "_idle"}, 64'(busy), 64'(0));
      end
   endtask

   initial begin
      int unsigned wt;
      int unsigned extra;
      for (int k = 0; k < NF; k++) begin
         dat[k]    = FW'(k + 1);
         lat[k]    = 3;
         silent[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_conv", 64'(adc_conv), 64'(0));
      chk("rst_sel", 64'(adc_ch_sel), 64'(0));
      chk("rst_feat", 64'(feat_vec), 64'(0));
      chk("rst_cls", 64'(cls_out), 64'(0));
      chk("rst_valid", 64'(cls_valid), 64'(0));
`ifdef MLP_SEQ_TIMEOUT_EN
      chk("rst_err", 64'(adc_err), 64'(0));
`endif
      rst = 1'b0;
      @(negedge clk);

      run("nom", 1'b0, 0, 2'b10);
      chk("nom_vec", 64'(feat_vec), 64'h654321);

      randomize_adc();
      run("busy_start", 1'b0, 10, CW'($urandom));
      extra = 0;
      repeat (60) begin
         @(negedge clk);
         if (busy || cls_valid) extra++;
      end
      chk("busy_no_restart", 64'(extra), 64'(0));

      randomize_adc();
      spur_arm = 1'b1;
      run("spur", 1'b0, 0, CW'($urandom));
      chk("spur_fired", 64'(spur_arm), 64'(0));

      randomize_adc();
      lat[3] = 6;
      conv_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wt = 0;
      while (conv_q.size() < 4 && wt < 200) begin
         @(negedge clk);
         wt++;
      end
      chk("rst_reach_ch3", 64'(conv_q.size()), 64'(4));
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_feat = '0;
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_conv", 64'(adc_conv), 64'(0));
      chk("arst_sel", 64'(adc_ch_sel), 64'(0));
      chk("arst_feat", 64'(feat_vec), 64'(exp_feat));
      chk("arst_cls", 64'(cls_out), 64'(0));
      chk("arst_valid", 64'(cls_valid), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("late_done_feat", 64'(feat_vec), 64'(exp_feat));
      chk("late_done_idle", 64'(busy), 64'(0));
      randomize_adc();
      run("post_rst", 1'b0, 0, CW'($urandom));

      randomize_adc();
      run("b2b_a", 1'b1, 0, CW'($urandom));
      randomize_adc();
      run("b2b_b", 1'b0, 0, CW'($urandom));

      for (int r = 0; r < 6; r++) begin
         randomize_adc();
         run("rnd", 1'b0, 0, CW'($urandom));
      end

`ifdef MLP_SEQ_TIMEOUT_EN
      randomize_adc();
      silent[4] = 1'b1;
      run("tmo", 1'b0, 0, CW'($urandom));
      chk("tmo_err", 64'(adc_err), 64'(1));
      randomize_adc();
      run("tmo_next", 1'b0, 0, CW'($urandom));
      chk("tmo_sticky", 64'(adc_err), 64'(1));
      rst = 1'b1;
      #1;
      chk("tmo_rst_clr", 64'(adc_err), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
      $fatal(1);
   end

endmodule
